// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared widths and control types for the systolic array PEs
package systolic_pkg;
  localparam int DATA_W    = 16;
  localparam int PROD_W    = 2 * DATA_W;
  localparam int ACC_W_DEF = 40;

  typedef struct packed {
    logic valid;
    logic last;
  } pe_ctrl_t;
endpackage

// File: rtl/systolic_pe_mac_wallace.sv
// rtl/systolic_pe_mac_wallace.sv - combinational 16x16 unsigned Wallace tree multiplier
module systolic_pe_mac_wallace
  import systolic_pkg::*;
#(
  parameter int APPROX = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  // Low columns that use approximate (OR-based, carry-free) compressors when APPROX=1
  localparam int APPROX_COLS = 4;
  localparam logic [PROD_W-1:0] AMASK = (APPROX != 0) ? PROD_W'((1 << APPROX_COLS) - 1) : '0;

  // Partial products reduced by rounds of 3:2 compressors down to two rows, then one adder
  always_comb begin
    logic [PROD_W-1:0] rows [DATA_W];
    logic [PROD_W-1:0] nxt [DATA_W];
    logic [PROD_W-1:0] x, y, z;
    int n, m;
    for (int i = 0; i < DATA_W; i++) begin
      rows[i] = b[i] ? ({{DATA_W{1'b0}}, a} << i) : '0;
      nxt[i]  = '0;
    end
    x = '0;
    y = '0;
    z = '0;
    n = DATA_W;
    m = 0;
    // 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows
    for (int s = 0; s < 6; s++) begin
      m = 0;
      for (int i = 0; i < DATA_W; i++) nxt[i] = '0;
      for (int g = 0; g < DATA_W / 3; g++) begin
        if (3 * g + 2 < n) begin
          x = rows[3 * g];
          y = rows[3 * g + 1];
          z = rows[3 * g + 2];
          nxt[m]     = ((x ^ y ^ z) & ~AMASK) | ((x | y | z) & AMASK);
          nxt[m + 1] = (((x & y) | (x & z) | (y & z)) & ~AMASK) << 1;
          m = m + 2;
        end
      end
      for (int r = 0; r < DATA_W; r++) begin
        if (r >= n - (n % 3) && r < n) begin
          nxt[m] = rows[r];
          m = m + 1;
        end
      end
      for (int i = 0; i < DATA_W; i++) rows[i] = nxt[i];
      n = m;
    end
    p = rows[0] + rows[1];
  end

endmodule

// File: rtl/systolic_pe_mac.sv
// rtl/systolic_pe_mac.sv - output-stationary PE: operand forwarding, MAC pipeline, result port
module systolic_pe_mac
  import systolic_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int APPROX = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              acc_clr,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  output logic              last_out,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_sat,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_lost
);

  pe_ctrl_t          s1_ctrl;
  pe_ctrl_t          s2_ctrl;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] prod_q;
  logic [ACC_W-1:0]  acc;
  logic              sat;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_next;
  logic              sat_next;
  logic              tile_done;

  // S1: forward operands unconditionally; internal control is killed by acc_clr
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      s1_ctrl   <= '0;
    end else begin
      a_out         <= a_in;
      b_out         <= b_in;
      valid_out     <= in_valid;
      last_out      <= in_last;
      s1_ctrl.valid <= in_valid & ~acc_clr;
      s1_ctrl.last  <= in_valid & in_last;
    end
  end

  systolic_pe_mac_wallace #(.APPROX(APPROX)) u_mult (
    .a (a_out),
    .b (b_out),
    .p (prod)
  );

  // S2: register the product alongside its control bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q  <= '0;
      s2_ctrl <= '0;
    end else begin
      prod_q        <= prod;
      s2_ctrl.valid <= s1_ctrl.valid & ~acc_clr;
      s2_ctrl.last  <= s1_ctrl.last;
    end
  end

  // Saturating sum: a carry out of ACC_W bits pins the accumulator at all-ones
  always_comb begin
    sum       = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_q};
    sat_next  = sat | sum[ACC_W];
    acc_next  = sat_next ? '1 : sum[ACC_W-1:0];
    tile_done = s2_ctrl.valid & s2_ctrl.last & ~acc_clr;
  end

  // S3: accumulate; the accumulator restarts at zero on the tile-end edge
  always_ff @(posedge clk) begin
    if (!rst_n || acc_clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (s2_ctrl.valid) begin
      if (s2_ctrl.last) begin
        acc <= '0;
        sat <= 1'b0;
      end else begin
        acc <= acc_next;
        sat <= sat_next;
      end
    end
  end

  // Result port: hold until accepted; a result arriving while stalled is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data  <= '0;
      res_sat   <= 1'b0;
      res_valid <= 1'b0;
      res_lost  <= 1'b0;
    end else if (tile_done) begin
      if (res_valid && !res_ready) begin
        res_lost <= 1'b1;
      end else begin
        res_data  <= acc_next;
        res_sat   <= sat_next;
        res_valid <= 1'b1;
      end
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
